imem_jtag_loader: RTL and testbench
===================================

# imem_jtag_loader

Downstream consumer of the 97-bit I-Mem JTAG data register (IR = 0x80). On every Update-DR of that chain it synchronises the update strobe into the system clock domain, decodes the held 97-bit word as an instruction-memory write or read command, and executes it on the I-Mem port with a valid/ready handshake. It also returns a 97-bit status/readback word that drives the DR's `data_i` capture input, so the next Capture-DR shifts the result out.

## Interface
Parameters:
- `ADDR_W`, 64: I-Mem byte address width.
- `DATA_W`, 32: instruction word width.
- `DR_W`, 97: JTAG DR width; must equal `1 + ADDR_W + DATA_W`.

Ports:
- `clk_i` input 1: system clock; the only clock of the block.
- `rst_ni` input 1: reset, synchronous, active-low.
- `im_upd_i` input 1: I-Mem DR update strobe from the TAP; asynchronous to `clk_i`.
- `im_data_i` input DR_W: DR update-latch output; stable from the `im_upd_i` rise until the next Update-DR.
- `clr_err_i` input 1: one-cycle pulse that clears the sticky error flags.
- `mem_valid_o` output 1: I-Mem request valid.
- `mem_we_o` output 1: 1 = write, 0 = read.
- `mem_addr_o` output ADDR_W: request byte address.
- `mem_wdata_o` output DATA_W: write data.
- `mem_ready_i` input 1: I-Mem accepts the request in a cycle where valid and ready are both high.
- `mem_rvalid_i` input 1: read data valid, one cycle.
- `mem_rdata_i` input DATA_W: read data.
- `capture_o` output DR_W: `{busy_o, last_addr[ADDR_W-1:0], rdata[DATA_W-1:0]}`; feeds the DR's `data_i`.
- `busy_o` output 1: FSM is not in IDLE.
- `err_overrun_o` output 1: sticky; a command arrived while busy.
- `err_misalign_o` output 1: sticky; a command address had `addr[1:0] != 0`.
- `wr_cnt_o` output 16: count of completed writes, saturating.

## Operation
- Command fields:
  - `im_data_i[96]` = we.
  - `im_data_i[95:32]` = addr.
  - `im_data_i[31:0]` = wdata.
- Strobe synchroniser: 3-flop chain s1→s2→s3 on `im_upd_i`. `upd_evt = s2 & ~s3`, so each rise of `im_upd_i` yields exactly one event. A level held high produces no further events.
- FSM states: IDLE, REQ, RWAIT.
- IDLE:
  - On `upd_evt`, register `im_data_i` into the command register and set `last_addr` = addr.
  - If `addr[1:0] != 0`: set `err_misalign_o`, issue no request, stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - Drive `mem_valid_o = 1` with `mem_we_o`, `mem_addr_o` and `mem_wdata_o` from the command register, held constant until accepted.
  - On `mem_ready_i`, a write goes to IDLE and increments `wr_cnt_o` (saturates at 0xFFFF); a read goes to RWAIT.
- RWAIT: on `mem_rvalid_i`, load `rdata` from `mem_rdata_i` and go to IDLE. `mem_valid_o = 0` in this state.
- `upd_evt` while in REQ or RWAIT: drop the command, set `err_overrun_o`, and continue the current transaction unchanged.
- Simultaneous `clr_err_i` and an error-setting event in the same cycle: the set wins.
- `mem_rvalid_i` outside RWAIT is ignored.
- Writes leave `rdata` unchanged.
- `capture_o` is purely registered state and updates the cycle after the source registers change.

## Timing
- Reset values (while `rst_ni` is sampled low): FSM in IDLE, s1/s2/s3 = 0, and every output is 0, including `capture_o`, `wr_cnt_o` and both error flags.
- Reset asserted mid-transaction: the request is abandoned at the next edge and `mem_valid_o` is 0 in the following cycle. A pending event in the synchroniser is lost.
- Event latency: let k be the first `clk_i` edge that samples `im_upd_i` high.
  - `upd_evt` is high in cycle k+1..k+2.
  - The command is registered at edge k+2.
  - `mem_valid_o` is high from edge k+2.
- Write with `mem_ready_i` already high: accepted at edge k+3; `busy_o` = 0 and `wr_cnt_o` incremented after edge k+3.
- Read: `rdata` and `capture_o[31:0]` are updated at the edge after the `mem_rvalid_i` cycle.
- Handshake: `mem_valid_o` is never deasserted before acceptance. Address and data are stable while valid is high.
- Throughput: at most one command per 3 clk cycles plus the memory latency. The TAP's Update→Capture spacing (≥3 TCK) must exceed this. Otherwise the command is flagged as an overrun; it is not queued.

## Test plan
- Reset, then a write: `im_data_i = {1'b1, 64'h0000_0000_0000_0100, 32'h0000_0013}` with an `im_upd_i` pulse and `mem_ready_i = 1`. Required: exactly one request with addr 0x100 and wdata 0x13; `mem_valid_o` high from edge k+2; `wr_cnt_o` = 1; `busy_o` returns to 0.
- Read with backpressure: a read command at addr 0x100, `mem_ready_i` low for 4 cycles, then `mem_rvalid_i` 2 cycles later with 0xA5A5A5A5. Required: request fields stable through the stall; `capture_o = {1'b0, 64'h100, 32'hA5A5A5A5}`.
- Misaligned command: addr 0x102. Required: no `mem_valid_o`; `err_misalign_o` = 1; a `clr_err_i` pulse clears it.
- Overrun: a second `im_upd_i` rise while in RWAIT (`mem_rvalid_i` held off). Required: `err_overrun_o` = 1; the first read completes normally; no second request is issued.
- Long strobe: `im_upd_i` held high for 20 cycles. Required: exactly one request. Also, `rst_ni` asserted low while in REQ: required `mem_valid_o` = 0 the cycle after the reset edge and all outputs at 0.
- Counter saturation: force `wr_cnt_o` to 0xFFFF, then run one more write. Required: `wr_cnt_o` stays at 0xFFFF.

Source files
------------

// File: rtl/imem_jtag_loader.sv
// Turns each Update-DR of the 97-bit I-Mem JTAG chain into one I-Mem write or read.
// Also returns a status/readback word that feeds the DR capture input.
module imem_jtag_loader #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int DR_W   = 97
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              im_upd_i,
  input  logic [DR_W-1:0]   im_data_i,
  input  logic              clr_err_i,
  output logic              mem_valid_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DR_W-1:0]   capture_o,
  output logic              busy_o,
  output logic              err_overrun_o,
  output logic              err_misalign_o,
  output logic [15:0]       wr_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;

  logic              s1, s2, s3;
  logic              upd_evt;
  logic [1:0]        state;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] rdata;
  logic [15:0]       wr_cnt;
  logic              err_overrun;
  logic              err_misalign;

  logic              in_we;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_misaligned;
  logic              accept;
  logic              set_overrun;
  logic              set_misalign;

  assign in_we         = im_data_i[DR_W-1];
  assign in_addr       = im_data_i[DATA_W +: ADDR_W];
  assign in_wdata      = im_data_i[DATA_W-1:0];
  assign in_misaligned = |in_addr[1:0];

  // s1 resolves metastability; the s2/s3 edge detect gives one event per rise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= im_upd_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign upd_evt      = s2 & ~s3;
  assign accept       = (state == REQ) & mem_ready_i;
  assign set_overrun  = upd_evt & (state != IDLE);
  assign set_misalign = upd_evt & (state == IDLE) & in_misaligned;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      last_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_evt) begin
            cmd_we    <= in_we;
            cmd_addr  <= in_addr;
            cmd_wdata <= in_wdata;
            last_addr <= in_addr;
            state     <= in_misaligned ? IDLE : REQ;
          end
        end
        REQ: begin
          if (mem_ready_i) state <= cmd_we ? IDLE : RWAIT;
        end
        RWAIT: begin
          if (mem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata <= '0;
    end else if ((state == RWAIT) && mem_rvalid_i) begin
      rdata <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
    end else if (accept && cmd_we && (wr_cnt != 16'hFFFF)) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Setting an error takes priority over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_overrun  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (set_overrun)    err_overrun <= 1'b1;
      else if (clr_err_i) err_overrun <= 1'b0;
      if (set_misalign)   err_misalign <= 1'b1;
      else if (clr_err_i) err_misalign <= 1'b0;
    end
  end

  assign mem_valid_o    = (state == REQ);
  assign mem_we_o       = cmd_we;
  assign mem_addr_o     = cmd_addr;
  assign mem_wdata_o    = cmd_wdata;
  assign busy_o         = (state != IDLE);
  assign err_overrun_o  = err_overrun;
  assign err_misalign_o = err_misalign;
  assign wr_cnt_o       = wr_cnt;
  assign capture_o      = {busy_o, last_addr, rdata};

endmodule

// File: tb/tb_imem_jtag_loader.sv
// Directed bench for imem_jtag_loader: write, stalled read, misalign, overrun,
// long strobe, mid-transaction reset and write-counter saturation.
module tb_imem_jtag_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        im_upd_i;
  logic [96:0] im_data_i;
  logic        clr_err_i;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [96:0] capture_o;
  logic        busy_o;
  logic        err_overrun_o;
  logic        err_misalign_o;
  logic [15:0] wr_cnt_o;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  logic [63:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  imem_jtag_loader dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .im_upd_i       (im_upd_i),
    .im_data_i      (im_data_i),
    .clr_err_i      (clr_err_i),
    .mem_valid_o    (mem_valid_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .capture_o      (capture_o),
    .busy_o         (busy_o),
    .err_overrun_o  (err_overrun_o),
    .err_misalign_o (err_misalign_o),
    .wr_cnt_o       (wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts accepted requests on the memory side.
  always @(posedge clk_i) begin
    if (rst_ni && mem_valid_o && mem_ready_i) begin
      req_cnt   <= req_cnt + 1;
      req_addr  <= mem_addr_o;
      req_wdata <= mem_wdata_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [96:0] observed,
                             input logic [96:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Loads the DR word and gives one strobe pulse; returns at the negedge after edge k.
  task automatic applyStimulus(input logic we, input logic [63:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk_i);
    im_data_i = {we, addr, wdata};
    im_upd_i  = 1'b1;
    @(negedge clk_i);
    im_upd_i  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    rst_ni       = 1'b0;
    im_upd_i     = 1'b0;
    im_data_i    = '0;
    clr_err_i    = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;

    // Reset state
    waitCycles(3);
    checkOutput("rst_capture", capture_o, 97'd0);
    checkOutput("rst_valid", 97'(mem_valid_o), 97'd0);
    checkOutput("rst_busy", 97'(busy_o), 97'd0);
    checkOutput("rst_wrcnt", 97'(wr_cnt_o), 97'd0);
    checkOutput("rst_errs", 97'({err_overrun_o, err_misalign_o}), 97'd0);
    rst_ni = 1'b1;
    waitCycles(2);

    // Write with ready already high
    mem_ready_i = 1'b1;
    applyStimulus(1'b1, 64'h100, 32'h13);
    @(negedge clk_i);
    checkOutput("wr_valid_k1", 97'(mem_valid_o), 97'd0);
    @(negedge clk_i);
    checkOutput("wr_valid_k2", 97'(mem_valid_o), 97'd1);
    checkOutput("wr_fields", 97'({mem_we_o, mem_addr_o, mem_wdata_o}),
                {1'b1, 64'h100, 32'h13});
    @(negedge clk_i);
    checkOutput("wr_busy_done", 97'(busy_o), 97'd0);
    checkOutput("wr_cnt_1", 97'(wr_cnt_o), 97'd1);
    waitCycles(3);
    checkOutput("wr_req_cnt", 97'(req_cnt), 97'd1);
    checkOutput("wr_req_addr", 97'(req_addr), 97'h100);
    checkOutput("wr_req_wdata", 97'(req_wdata), 97'h13);
    checkOutput("wr_capture", capture_o, {1'b0, 64'h100, 32'h0});

    // Read with 4 stall cycles, then rvalid 2 cycles after acceptance
    mem_ready_i = 1'b0;
    applyStimulus(1'b0, 64'h100, 32'h0);
    waitCycles(2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd_stall", 97'({mem_valid_o, mem_we_o, mem_addr_o}),
                  97'({1'b1, 1'b0, 64'h100}));
      if (i < 3) @(negedge clk_i);
    end
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    checkOutput("rd_rwait", 97'({mem_valid_o, busy_o}), 97'b01);
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA5A5A5A5;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    checkOutput("rd_capture", capture_o, {1'b0, 64'h100, 32'hA5A5A5A5});
    checkOutput("rd_req_cnt", 97'(req_cnt), 97'd2);

    // Misaligned command
    mem_ready_i = 1'b1;
    applyStimulus(1'b1, 64'h102, 32'h55);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("mis_no_valid", 97'(mem_valid_o), 97'd0);
    end
    checkOutput("mis_err", 97'(err_misalign_o), 97'd1);
    checkOutput("mis_capture", capture_o, {1'b0, 64'h102, 32'hA5A5A5A5});
    checkOutput("mis_wrcnt", 97'(wr_cnt_o), 97'd1);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    checkOutput("mis_cleared", 97'(err_misalign_o), 97'd0);

    // Overrun: second strobe while waiting for read data
    applyStimulus(1'b0, 64'h200, 32'h0);
    waitCycles(3);
    checkOutput("ov_in_rwait", 97'({mem_valid_o, busy_o}), 97'b01);
    applyStimulus(1'b1, 64'h300, 32'h77);
    waitCycles(3);
    checkOutput("ov_err", 97'(err_overrun_o), 97'd1);
    checkOutput("ov_still_busy", 97'(busy_o), 97'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h12345678;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    checkOutput("ov_capture", capture_o, {1'b0, 64'h200, 32'h12345678});
    waitCycles(4);
    checkOutput("ov_req_cnt", 97'(req_cnt), 97'd3);
    checkOutput("ov_wrcnt", 97'(wr_cnt_o), 97'd1);

    // Long strobe held for 20 cycles
    @(negedge clk_i);
    im_data_i = {1'b1, 64'h400, 32'h99};
    im_upd_i  = 1'b1;
    waitCycles(20);
    im_upd_i  = 1'b0;
    waitCycles(4);
    checkOutput("long_req_cnt", 97'(req_cnt), 97'd4);
    checkOutput("long_wrcnt", 97'(wr_cnt_o), 97'd2);
    checkOutput("long_req_addr", 97'(req_addr), 97'h400);

    // Reset asserted while in REQ
    mem_ready_i = 1'b0;
    applyStimulus(1'b1, 64'h500, 32'hAA);
    waitCycles(2);
    checkOutput("rreq_valid", 97'(mem_valid_o), 97'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("rreq_valid_off", 97'(mem_valid_o), 97'd0);
    checkOutput("rreq_capture", capture_o, 97'd0);
    checkOutput("rreq_outs", 97'({busy_o, err_overrun_o, err_misalign_o, wr_cnt_o,
                                  mem_we_o, mem_addr_o}), 97'd0);
    rst_ni = 1'b1;
    waitCycles(4);
    checkOutput("rreq_no_req", 97'(req_cnt), 97'd4);

    // Counter saturation
    force dut.wr_cnt = 16'hFFFF;
    @(negedge clk_i);
    release dut.wr_cnt;
    @(negedge clk_i);
    checkOutput("sat_forced", 97'(wr_cnt_o), 97'hFFFF);
    mem_ready_i = 1'b1;
    applyStimulus(1'b1, 64'h600, 32'h1);
    waitCycles(4);
    checkOutput("sat_req_cnt", 97'(req_cnt), 97'd5);
    checkOutput("sat_wrcnt", 97'(wr_cnt_o), 97'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
